io_port_controller: RTL and testbench
=====================================

# io_port_controller

Peripheral-side endpoint of the processor's 16-bit I/O port. It accepts words the processor drives on its `write_out` bus and queues them in an outbound FIFO toward an external host with a valid/ready handshake. It also accepts words from the host with a valid/ready handshake, holds each one in a single-entry register, and presents it on the processor's `read_in` bus until the processor consumes it. It sits at the top level between the processor core and the off-chip or testbench host.

## Interface

**Parameters**
- `DEPTH`, default 4: outbound FIFO entries. Must be a power of two and ≥ 2.
- `WIDTH`, default 16: data word width. Must match the processor datapath.

**Ports**
- `clock`  in  1: single clock. All state updates on posedge.
- `rst`  in  1: asynchronous, active-low reset. `rst`=0 clears all state immediately.
- `cpu_write_out`  in  WIDTH: processor `write_out` bus.
- `cpu_wr_strobe`  in  1: one-cycle qualifier. When high, the current `cpu_write_out` is an I/O store.
- `cpu_rd_strobe`  in  1: one-cycle qualifier. When high, the processor consumed `cpu_read_in` this cycle.
- `cpu_read_in`  out  WIDTH: drives processor `read_in`.
- `cpu_in_valid`  out  1: `cpu_read_in` holds an unconsumed host word.
- `host_out_data`  out  WIDTH: FIFO head word.
- `host_out_valid`  out  1: FIFO non-empty.
- `host_out_ready`  in  1: host accepts the head word this cycle.
- `host_in_data`  in  WIDTH: host word.
- `host_in_valid`  in  1: host offers `host_in_data`.
- `host_in_ready`  out  1: holding register empty.
- `out_count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_count`  out  8: present only with `IO_PORT_DROP_COUNT_EN`.

## Operation

**Outbound path**
- Push: `cpu_wr_strobe`=1 and (not full, or pop in the same cycle) writes `cpu_write_out` at the write pointer.
- Pop: `host_out_valid` & `host_out_ready`.
- Push when full with no pop: the word is dropped. FIFO contents and pointers are unchanged.
- Push and pop in the same cycle:
  - Count is unchanged.
  - This is legal even when full.
  - It is impossible when empty, because `host_out_valid`=0. There is no fall-through path.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Count is `$clog2(DEPTH)+1` bits and ranges 0..DEPTH.
- `host_out_data` is the head entry. Its value is don't-care while `host_out_valid`=0.

**Inbound path**
- The holding register has two states:
  - EMPTY: `host_in_ready`=1, `cpu_in_valid`=0.
  - FULL: `host_in_ready`=0, `cpu_in_valid`=1.
- EMPTY→FULL on `host_in_valid` & `host_in_ready`. The register loads `host_in_data`.
- FULL→EMPTY on `cpu_rd_strobe`.
- `cpu_rd_strobe` while EMPTY is ignored.
- `cpu_read_in` always shows the last loaded word. It is not zeroed on consume.
- `host_in_valid` while FULL is ignored. The host must hold its data until it sees ready.

## Timing

**Reset values (`rst`=0)**
- FIFO pointers and count = 0.
- `host_out_valid` = 0.
- `cpu_read_in` = 0.
- `cpu_in_valid` = 0.
- Inbound state = EMPTY. `host_in_ready` is forced to 0 while `rst`=0 and goes to 1 in the first cycle after release.
- `drop_count` = 0.

**Latencies**
- Outbound, strobe to host: a push at edge n sets `host_out_valid`=1 after edge n.
- `host_out_valid`, `cpu_in_valid` and `host_in_ready` are decoded directly from registered state. There are no combinational paths from inputs to these outputs.
- Inbound, host to CPU: an accept at edge n gives `cpu_in_valid`=1 and new `cpu_read_in` after edge n.
- Inbound refill: a consume at edge n gives `host_in_ready`=1 after edge n. Peak inbound throughput is therefore 1 word per 2 cycles.
- Outbound sustained throughput is 1 word/cycle.

**Reset mid-operation**
- All queued and held words are lost.
- A host transfer in flight during reset is not accepted.

## Configuration

`IO_PORT_DROP_COUNT_EN`
- **Defined:**
  - `drop_count` port exists.
  - It increments by 1 on every dropped push (full, no pop).
  - It saturates at 255. It is cleared only by reset.
- **Undefined:**
  - The port and counter are absent.
  - Drops are silent.
  - All other behaviour is identical.

## Test plan

1. **Reset.** Hold `rst`=0 for 3 cycles with random inputs → all outputs are 0. Release → `host_in_ready`=1 next cycle.
2. **Outbound ordering.** DEPTH=4, `host_out_ready`=0. Strobe 0x1111, 0x2222, 0x3333, 0x4444 → `out_count`=4. Raise ready → host sees the four words in order, one per cycle. `host_out_valid` falls after the 4th.
3. **Overflow.** With the FIFO full, strobe 0xDEAD without a pop → 0xDEAD never appears and `out_count` stays 4. With the macro, `drop_count`=1. Strobe 300 more drops → `drop_count`=255.
4. **Full simultaneous push/pop.** FIFO full, ready=1, strobe 0x5555 → count stays 4. 0x5555 emerges 4 pops later, with pointer wrap exercised.
5. **Inbound.** Host offers 0xABCD → `cpu_in_valid`=1 with `cpu_read_in`=0xABCD next cycle, and `host_in_ready`=0. A second host word 0x1234 is held off until `cpu_rd_strobe`. Then ready=1 and 0x1234 loads the following cycle. A strobe while EMPTY causes no change.
6. **Reset mid-operation.** 2 words queued and inbound FULL, assert `rst` asynchronously between edges → `host_out_valid`, `cpu_in_valid` and count drop to 0 immediately.

Source files
------------

// File: rtl/io_port_controller_if.sv
// Processor I/O-port and host handshake bundle for io_port_controller.
// The drop_count member exists only when IO_PORT_DROP_COUNT_EN is defined.
interface io_port_controller_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] cpu_write_out;
    logic             cpu_wr_strobe;
    logic             cpu_rd_strobe;
    logic [WIDTH-1:0] cpu_read_in;
    logic             cpu_in_valid;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [CW-1:0]    out_count;
`ifdef IO_PORT_DROP_COUNT_EN
    logic [7:0]       drop_count;
`endif

    // master: processor core plus host; slave: the controller itself
    modport master (
`ifdef IO_PORT_DROP_COUNT_EN
        input  drop_count,
`endif
        output cpu_write_out, cpu_wr_strobe, cpu_rd_strobe,
        output host_out_ready, host_in_data, host_in_valid,
        input  cpu_read_in, cpu_in_valid, host_out_data, host_out_valid,
        input  host_in_ready, out_count
    );

    modport slave (
`ifdef IO_PORT_DROP_COUNT_EN
        output drop_count,
`endif
        input  cpu_write_out, cpu_wr_strobe, cpu_rd_strobe,
        input  host_out_ready, host_in_data, host_in_valid,
        output cpu_read_in, cpu_in_valid, host_out_data, host_out_valid,
        output host_in_ready, out_count
    );
endinterface

// File: rtl/io_port_controller.sv
// Processor I/O-port endpoint: outbound FIFO toward the host, single-entry inbound holding register.
// Optional saturating drop counter enabled by IO_PORT_DROP_COUNT_EN.
module io_port_controller #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input logic                 clock,
    input logic                 rst,
    io_port_controller_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ---------------- outbound FIFO ----------------
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               count;
    logic                        full, pop, push;

    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) && bus.host_out_ready;
    // a pop frees the head slot this cycle, so a full FIFO still takes the push
    assign push = bus.cpu_wr_strobe && (!full || pop);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.cpu_write_out;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign bus.host_out_data  = mem[rd_ptr];
    assign bus.host_out_valid = (count != '0);
    assign bus.out_count      = count;

`ifdef IO_PORT_DROP_COUNT_EN
    logic [7:0] drop_q;
    logic       drop;

    assign drop = bus.cpu_wr_strobe && full && !pop;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            drop_q <= '0;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign bus.drop_count = drop_q;
`endif

    // ---------------- inbound holding register ----------------
    typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;

    in_state_t        state, state_nxt;
    logic             live;
    logic             load;
    logic [WIDTH-1:0] hold;

    // live keeps host_in_ready low until the first edge after reset release
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IN_EMPTY;
            live  <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            if (load)
                hold <= bus.host_in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IN_EMPTY: if (live && bus.host_in_valid) begin
                state_nxt = IN_FULL;
                load      = 1'b1;
            end
            IN_FULL:  if (bus.cpu_rd_strobe)
                state_nxt = IN_EMPTY;
            default:  state_nxt = IN_EMPTY;
        endcase
    end

    assign bus.host_in_ready = live && (state == IN_EMPTY);
    assign bus.cpu_in_valid  = (state == IN_FULL);
    assign bus.cpu_read_in   = hold;
endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: scoreboard of outbound words plus inbound/reset checks.
module tb_io_port_controller;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic clock;
    logic rst;

    io_port_controller_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    io_port_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb[$];
    int               mc;  // model occupancy
    int               dc;  // model drop count

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock: model pop/push from the current inputs, compare the popped word, advance.
    task automatic cycle();
        logic pop_m, push_m;
        logic [WIDTH-1:0] exp_w;
        pop_m  = (mc != 0) && bus.host_out_ready;
        push_m = bus.cpu_wr_strobe && (mc < DEPTH || pop_m);
        if (pop_m) begin
            exp_w = sb.pop_front();
            check("pop_valid", 32'(bus.host_out_valid), 32'd1);
            check("pop_data", 32'(bus.host_out_data), 32'(exp_w));
            mc--;
        end
        if (push_m) begin
            sb.push_back(bus.cpu_write_out);
            mc++;
        end
        if (bus.cpu_wr_strobe && !push_m && dc < 255)
            dc++;
        tick();
        check("out_count", 32'(bus.out_count), 32'(mc));
        check("out_valid", 32'(bus.host_out_valid), 32'(mc != 0));
    endtask

    task automatic idle_inputs();
        bus.cpu_write_out  = '0;
        bus.cpu_wr_strobe  = 1'b0;
        bus.cpu_rd_strobe  = 1'b0;
        bus.host_out_ready = 1'b0;
        bus.host_in_data   = '0;
        bus.host_in_valid  = 1'b0;
    endtask

    initial begin
        mc = 0;
        dc = 0;
        rst = 1'b0;
        idle_inputs();

        // ---- reset with random inputs ----
        for (int i = 0; i < 3; i++) begin
            bus.cpu_write_out  = 16'($urandom);
            bus.cpu_wr_strobe  = 1'($urandom);
            bus.cpu_rd_strobe  = 1'($urandom);
            bus.host_out_ready = 1'($urandom);
            bus.host_in_data   = 16'($urandom);
            bus.host_in_valid  = 1'($urandom);
            tick();
        end
        check("rst_out_valid", 32'(bus.host_out_valid), 32'd0);
        check("rst_in_valid", 32'(bus.cpu_in_valid), 32'd0);
        check("rst_in_ready", 32'(bus.host_in_ready), 32'd0);
        check("rst_count", 32'(bus.out_count), 32'd0);
        check("rst_read_in", 32'(bus.cpu_read_in), 32'd0);
        check("rst_out_data", 32'(bus.host_out_data), 32'd0);
`ifdef IO_PORT_DROP_COUNT_EN
        check("rst_drop", 32'(bus.drop_count), 32'd0);
`endif
        idle_inputs();
        rst = 1'b1;
        tick();
        check("rel_in_ready", 32'(bus.host_in_ready), 32'd1);
        check("rel_in_valid", 32'(bus.cpu_in_valid), 32'd0);

        // ---- outbound ordering ----
        for (int i = 0; i < 4; i++) begin
            bus.cpu_wr_strobe = 1'b1;
            bus.cpu_write_out = 16'(16'h1111 * (i + 1));
            cycle();
        end
        bus.cpu_wr_strobe = 1'b0;
        check("fill_count", 32'(bus.out_count), 32'd4);
        bus.host_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("drain_valid", 32'(bus.host_out_valid), 32'd0);

        // ---- overflow ----
        bus.host_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_wr_strobe = 1'b1;
            bus.cpu_write_out = 16'(16'h1111 * (i + 6));
            cycle();
        end
        bus.cpu_write_out = 16'hDEAD;
        cycle();
        check("ovf_count", 32'(bus.out_count), 32'd4);
`ifdef IO_PORT_DROP_COUNT_EN
        check("drop_one", 32'(bus.drop_count), 32'(dc));
`endif
        for (int i = 0; i < 300; i++) begin
            bus.cpu_write_out = 16'($urandom);
            cycle();
        end
`ifdef IO_PORT_DROP_COUNT_EN
        check("drop_sat", 32'(bus.drop_count), 32'd255);
`endif

        // ---- full simultaneous push/pop ----
        bus.host_out_ready = 1'b1;
        bus.cpu_write_out  = 16'h5555;
        cycle();
        check("full_pp_count", 32'(bus.out_count), 32'd4);
        bus.cpu_wr_strobe = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("pp_drained", 32'(bus.host_out_valid), 32'd0);

        // ---- sustained one word per cycle ----
        for (int i = 0; i < 6; i++) begin
            bus.cpu_wr_strobe = 1'b1;
            bus.cpu_write_out = 16'(16'hA000 + i);
            cycle();
        end
        bus.cpu_wr_strobe = 1'b0;
        for (int i = 0; i < 8 && mc != 0; i++) cycle();
        check("burst_empty", 32'(mc), 32'd0);
        check("burst_sb", 32'(sb.size()), 32'd0);
        bus.host_out_ready = 1'b0;

        // ---- inbound ----
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'hABCD;
        cycle();
        check("in_valid", 32'(bus.cpu_in_valid), 32'd1);
        check("in_data", 32'(bus.cpu_read_in), 32'hABCD);
        check("in_ready_lo", 32'(bus.host_in_ready), 32'd0);
        bus.host_in_data = 16'h1234;
        cycle();
        cycle();
        check("held_off", 32'(bus.cpu_read_in), 32'hABCD);
        bus.cpu_rd_strobe = 1'b1;
        cycle();
        bus.cpu_rd_strobe = 1'b0;
        check("consumed", 32'(bus.cpu_in_valid), 32'd0);
        check("refill_ready", 32'(bus.host_in_ready), 32'd1);
        check("not_zeroed", 32'(bus.cpu_read_in), 32'hABCD);
        cycle();
        check("second_valid", 32'(bus.cpu_in_valid), 32'd1);
        check("second_data", 32'(bus.cpu_read_in), 32'h1234);
        bus.host_in_valid = 1'b0;
        bus.cpu_rd_strobe = 1'b1;
        cycle();
        cycle();  // strobe while EMPTY
        bus.cpu_rd_strobe = 1'b0;
        check("empty_rd_valid", 32'(bus.cpu_in_valid), 32'd0);
        check("empty_rd_ready", 32'(bus.host_in_ready), 32'd1);
        check("empty_rd_data", 32'(bus.cpu_read_in), 32'h1234);

        // ---- reset mid-operation ----
        bus.cpu_wr_strobe = 1'b1;
        bus.cpu_write_out = 16'h0C01;
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'h4242;
        cycle();
        bus.cpu_write_out = 16'h0C02;
        bus.host_in_valid = 1'b0;
        cycle();
        bus.cpu_wr_strobe = 1'b0;
        check("pre_rst_count", 32'(bus.out_count), 32'd2);
        check("pre_rst_in", 32'(bus.cpu_in_valid), 32'd1);
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'h7777;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.host_out_valid), 32'd0);
        check("mid_rst_in_valid", 32'(bus.cpu_in_valid), 32'd0);
        check("mid_rst_count", 32'(bus.out_count), 32'd0);
        check("mid_rst_ready", 32'(bus.host_in_ready), 32'd0);
`ifdef IO_PORT_DROP_COUNT_EN
        check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
`endif
        sb.delete();
        mc = 0;
        dc = 0;
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.host_in_ready), 32'd1);
        check("post_rst_no_accept", 32'(bus.cpu_in_valid), 32'd0);
        cycle();
        check("post_rst_load", 32'(bus.cpu_in_valid), 32'd1);
        check("post_rst_data", 32'(bus.cpu_read_in), 32'h7777);
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
